// File: rtl/seq_pkg.sv
// Shared definitions for the sequencer core: opcodes, instruction field
// positions, the control state enum and an index range helper.
package seq_pkg;

  localparam logic [7:0] OP_WAIT   = 8'h01;
  localparam logic [7:0] OP_ON     = 8'h02;
  localparam logic [7:0] OP_OFF    = 8'h03;
  localparam logic [7:0] OP_WAITIN = 8'h06;
  localparam logic [7:0] OP_SET    = 8'h11;
  localparam logic [7:0] OP_DEC    = 8'h12;
  localparam logic [7:0] OP_J      = 8'h20;
  localparam logic [7:0] OP_JZ     = 8'h21;
  localparam logic [7:0] OP_JNZ    = 8'h22;
  localparam logic [7:0] OP_JTO    = 8'h23;
  localparam logic [7:0] OP_CALL   = 8'h24;
  localparam logic [7:0] OP_RET    = 8'h25;
  localparam logic [7:0] OP_HALT   = 8'h3F;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 7;
  localparam int IDX_LSB = 8;
  localparam int IDX_MSB = 15;
  localparam int ARG_LSB = 16;
  localparam int ARG_MSB = 31;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT_T = 2'd1,
    ST_WAIT_S = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  function automatic logic idx_ok(input logic [7:0] idx, input int limit);
    return ({24'd0, idx} < 32'(limit));
  endfunction

endpackage

// File: rtl/seq_stack.sv
// Return-address LIFO for CALL/RET. The top entry is visible combinationally
// so RET can load pc in the same edge that pops.
module seq_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign wr_idx  = AW'(cnt_q);
  assign top_idx = AW'(cnt_q - CW'(1));
  assign dout    = empty ? '0 : mem_q[top_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !full) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Entry contents need no reset; only the count defines what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/seq_core.sv
// Small instruction sequencer: drives latched actuators from a program fetched
// at pc, with timed and sensor waits, counters, branches and call/return.
module seq_core
  import seq_pkg::*;
#(
  parameter int REG_NUM     = 4,
  parameter int ACT_NUM     = 4,
  parameter int SENS_NUM    = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [31:0]           instr,
  input  logic [SENS_NUM-1:0]   sens,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ACT_NUM-1:0]    act,
  output logic                  busy,
  output logic                  halted,
  output logic                  err
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc, target;
  logic [ACT_NUM-1:0]    act_q, act_d, act_hit;
  logic [15:0]           timer_q, timer_d;
  logic                  flag_q, flag_d;
  logic                  err_q, err_d;

  logic [7:0]            opc;
  logic [7:0]            idx;
  logic [15:0]           arg;
  logic [SENS_NUM-1:0]   sens_hit;
  logic                  sens_sel;
  logic [15:0]           reg_val [REG_NUM];
  logic [15:0]           reg_sel;
  logic [15:0]           reg_wdata;
  logic                  reg_we;
  logic                  push, pop, stk_full, stk_empty;
  logic [ADDR_WIDTH-1:0] stk_top;
  logic                  fault;

  assign opc    = instr[OPC_MSB:OPC_LSB];
  assign idx    = instr[IDX_MSB:IDX_LSB];
  assign arg    = instr[ARG_MSB:ARG_LSB];
  assign target = arg[ADDR_WIDTH-1:0];
  assign pc_inc = pc_q + ADDR_WIDTH'(1);

  for (genvar gi = 0; gi < ACT_NUM; gi++) begin : g_act_hit
    assign act_hit[gi] = (idx == 8'(gi));
  end

  for (genvar gi = 0; gi < SENS_NUM; gi++) begin : g_sens_hit
    assign sens_hit[gi] = (idx == 8'(gi));
  end
  assign sens_sel = |(sens & sens_hit);

  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg
    logic [15:0] r_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (ena && reg_we && (idx == 8'(gi))) begin
        r_q <= reg_wdata;
      end
    end
    assign reg_val[gi] = r_q;
  end

  always_comb begin
    reg_sel = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (idx == 8'(i)) begin
        reg_sel = reg_val[i];
      end
    end
  end

  // Operands are range-checked per opcode; a bad one halts before any side effect.
  always_comb begin
    fault = 1'b0;
    case (opc)
      OP_WAIT, OP_J, OP_JTO, OP_HALT: fault = 1'b0;
      OP_ON, OP_OFF:                  fault = !idx_ok(idx, ACT_NUM);
      OP_WAITIN:                      fault = !idx_ok(idx, SENS_NUM);
      OP_SET, OP_DEC, OP_JZ, OP_JNZ:  fault = !idx_ok(idx, REG_NUM);
      OP_CALL:                        fault = stk_full;
      OP_RET:                         fault = stk_empty;
      default:                        fault = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    act_d     = act_q;
    timer_d   = timer_q;
    flag_d    = flag_q;
    err_d     = err_q;
    reg_we    = 1'b0;
    reg_wdata = arg;
    push      = 1'b0;
    pop       = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (fault) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          pc_d = pc_inc;
          case (opc)
            OP_WAIT: begin
              // The decode edge counts as the first of N+1 edges.
              if (arg != 16'd0) begin
                pc_d    = pc_q;
                timer_d = arg - 16'd1;
                state_d = ST_WAIT_T;
              end
            end
            OP_ON:  act_d = act_q | act_hit;
            OP_OFF: act_d = act_q & ~act_hit;
            OP_WAITIN: begin
              if (sens_sel) begin
                flag_d = 1'b0;
              end else if (arg < 16'd2) begin
                flag_d = 1'b1;
              end else begin
                pc_d    = pc_q;
                timer_d = arg - 16'd2;
                state_d = ST_WAIT_S;
              end
            end
            OP_SET: begin
              reg_we    = 1'b1;
              reg_wdata = arg;
            end
            OP_DEC: begin
              reg_we    = 1'b1;
              reg_wdata = reg_sel - 16'd1;
            end
            OP_J:   pc_d = target;
            OP_JZ:  pc_d = (reg_sel == 16'd0) ? target : pc_inc;
            OP_JNZ: pc_d = (reg_sel != 16'd0) ? target : pc_inc;
            OP_JTO: pc_d = flag_q ? target : pc_inc;
            OP_CALL: begin
              push = 1'b1;
              pc_d = target;
            end
            OP_RET: begin
              pop  = 1'b1;
              pc_d = stk_top;
            end
            OP_HALT: begin
              pc_d    = pc_q;
              state_d = ST_HALT;
            end
            default: pc_d = pc_q;
          endcase
        end
      end
      ST_WAIT_T: begin
        if (timer_q == 16'd0) begin
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_WAIT_S: begin
        // pc is held, so instr still carries the WAITIN sensor index.
        if (sens_sel) begin
          flag_d  = 1'b0;
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end else if (timer_q == 16'd0) begin
          flag_d  = 1'b1;
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      act_q   <= '0;
      timer_q <= '0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      act_q   <= act_d;
      timer_q <= timer_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
    end
  end

  seq_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push & ena),
    .pop   (pop & ena),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign pc     = pc_q;
  assign act    = act_q;
  assign busy   = (state_q == ST_WAIT_T) || (state_q == ST_WAIT_S);
  assign halted = (state_q == ST_HALT);
  assign err    = err_q;

endmodule

// File: tb/tb_seq_core.sv
// Self-checking bench for seq_core: directed programs plus random programs,
// compared every cycle against an instruction-level reference model.
module tb_seq_core;

  localparam logic [7:0] T_WAIT   = 8'h01;
  localparam logic [7:0] T_ON     = 8'h02;
  localparam logic [7:0] T_OFF    = 8'h03;
  localparam logic [7:0] T_WAITIN = 8'h06;
  localparam logic [7:0] T_SET    = 8'h11;
  localparam logic [7:0] T_DEC    = 8'h12;
  localparam logic [7:0] T_J      = 8'h20;
  localparam logic [7:0] T_JZ     = 8'h21;
  localparam logic [7:0] T_JNZ    = 8'h22;
  localparam logic [7:0] T_JTO    = 8'h23;
  localparam logic [7:0] T_CALL   = 8'h24;
  localparam logic [7:0] T_RET    = 8'h25;
  localparam logic [7:0] T_HALT   = 8'h3F;
  localparam int W_NONE = 0;
  localparam int W_TIME = 1;
  localparam int W_SENS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [3:0]  sens = '0;
  logic [31:0] instr;
  logic [7:0]  pc;
  logic [3:0]  act;
  logic        busy, halted, err;
  logic [31:0] prog [256];

  int checks = 0;
  int failures = 0;

  // Reference model: architectural state plus a deadline in enabled-edge time.
  int         m_pc;
  logic [3:0] m_act;
  int         m_reg [4];
  int         m_stack [$];
  bit         m_flag, m_err, m_halt;
  int         m_wait, m_deadline, m_idx;
  int         en_cnt = 0;

  assign instr = prog[pc];
  always #5 clk = ~clk;

  seq_core #(
    .REG_NUM     (4),
    .ACT_NUM     (4),
    .SENS_NUM    (4),
    .ADDR_WIDTH  (8),
    .STACK_DEPTH (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .instr  (instr),
    .sens   (sens),
    .pc     (pc),
    .act    (act),
    .busy   (busy),
    .halted (halted),
    .err    (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] ix, input logic [15:0] a);
    return {a, ix, op};
  endfunction

  task automatic clear_prog();
    for (int a = 0; a < 256; a++) prog[a] = mk(T_HALT, 8'd0, 16'd0);
  endtask

  task automatic model_step();
    logic [31:0] ins;
    logic [7:0]  op, ix;
    int a, k, nxt;
    bit bad;
    if (!rst_n) begin
      m_pc = 0; m_act = '0; m_flag = 0; m_err = 0; m_halt = 0; m_wait = W_NONE;
      foreach (m_reg[i]) m_reg[i] = 0;
      m_stack.delete();
      return;
    end
    if (!ena) return;
    k = en_cnt;
    en_cnt++;
    if (m_halt) return;
    nxt = (m_pc + 1) % 256;
    if (m_wait == W_TIME) begin
      if (k == m_deadline) begin m_wait = W_NONE; m_pc = nxt; end
      return;
    end
    if (m_wait == W_SENS) begin
      if (sens[m_idx]) begin m_flag = 0; m_wait = W_NONE; m_pc = nxt; end
      else if (k == m_deadline) begin m_flag = 1; m_wait = W_NONE; m_pc = nxt; end
      return;
    end
    ins = prog[m_pc];
    op = ins[7:0];
    ix = ins[15:8];
    a  = int'(ins[31:16]);
    case (op)
      T_WAIT, T_J, T_JTO, T_HALT: bad = 0;
      T_ON, T_OFF, T_WAITIN, T_SET, T_DEC, T_JZ, T_JNZ: bad = (ix >= 8'd4);
      T_CALL: bad = (m_stack.size() == 4);
      T_RET:  bad = (m_stack.size() == 0);
      default: bad = 1;
    endcase
    if (bad) begin m_err = 1; m_halt = 1; return; end
    case (op)
      T_WAIT: begin
        if (a == 0) m_pc = nxt;
        else begin m_wait = W_TIME; m_deadline = k + a; end
      end
      T_ON:  begin m_act[ix] = 1'b1; m_pc = nxt; end
      T_OFF: begin m_act[ix] = 1'b0; m_pc = nxt; end
      T_WAITIN: begin
        if (sens[ix]) begin m_flag = 0; m_pc = nxt; end
        else if (a <= 1) begin m_flag = 1; m_pc = nxt; end
        else begin m_wait = W_SENS; m_idx = int'(ix); m_deadline = k + a - 1; end
      end
      T_SET:  begin m_reg[ix] = a; m_pc = nxt; end
      T_DEC:  begin m_reg[ix] = (m_reg[ix] + 65535) % 65536; m_pc = nxt; end
      T_J:    m_pc = a % 256;
      T_JZ:   m_pc = (m_reg[ix] == 0) ? a % 256 : nxt;
      T_JNZ:  m_pc = (m_reg[ix] != 0) ? a % 256 : nxt;
      T_JTO:  m_pc = m_flag ? a % 256 : nxt;
      T_CALL: begin m_stack.push_back(nxt); m_pc = a % 256; end
      T_RET:  m_pc = m_stack.pop_back();
      default: m_halt = 1;
    endcase
  endtask

  task automatic tick(input logic r, input logic e, input logic [3:0] s);
    rst_n = r;
    ena   = e;
    sens  = s;
    model_step();
    @(posedge clk);
    #1;
    check_eq("pc_act_busy_halt_err", {17'd0, pc, act, busy, halted, err},
             {17'd0, m_pc[7:0], m_act, (m_wait != W_NONE), m_halt, m_err});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [7:0]  op, ix;
    logic [15:0] a;
    int sel;
    sel = $urandom_range(0, 15);
    ix = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
    a  = 16'd0;
    case (sel)
      0:       begin op = T_WAIT;   a = 16'($urandom_range(0, 6)); end
      1, 2:    op = T_ON;
      3:       op = T_OFF;
      4:       begin op = T_WAITIN; a = 16'($urandom_range(0, 8)); end
      5:       begin op = T_SET;    a = 16'($urandom_range(0, 4)); end
      6:       op = T_DEC;
      7:       begin op = T_J;      a = 16'($urandom_range(0, 31)); end
      8:       begin op = T_JZ;     a = 16'($urandom_range(0, 31)); end
      9:       begin op = T_JNZ;    a = 16'($urandom_range(0, 31)); end
      10:      begin op = T_JTO;    a = 16'($urandom_range(0, 31)); end
      11:      begin op = T_CALL;   a = 16'($urandom_range(0, 31)); end
      12:      op = T_RET;
      13:      op = T_HALT;
      14:      begin op = 8'($urandom_range(0, 255)); a = 16'($urandom_range(0, 31)); end
      default: op = T_DEC;
    endcase
    return mk(op, ix, a);
  endfunction

  initial begin
    int c_a, c_b;
    logic [3:0] s;

    // ON 1; WAIT 5; OFF 1
    clear_prog();
    prog[0] = mk(T_ON, 1, 0); prog[1] = mk(T_WAIT, 0, 5); prog[2] = mk(T_OFF, 1, 0);
    tick(0, 1, 0);
    check_eq("reset_pc", {24'd0, pc}, 0);
    check_eq("reset_flags", {28'd0, act, busy, halted, err}, 0);
    c_a = 0; c_b = 0;
    repeat (14) begin
      tick(1, 1, 0);
      if (act[1]) c_a++;
      if (pc == 8'd1) c_b++;
    end
    check_eq("wait5_act1_cycles", c_a, 7);
    check_eq("wait5_pc1_cycles", c_b, 6);
    $display("scenario on_wait_off done");

    // SET/DEC/JNZ loop, then JZ proves r0 reached zero
    clear_prog();
    prog[0] = mk(T_SET, 0, 3); prog[1] = mk(T_DEC, 0, 0); prog[2] = mk(T_JNZ, 0, 1);
    prog[3] = mk(T_JZ, 0, 5);  prog[4] = mk(8'h77, 0, 0);
    tick(0, 1, 0);
    c_a = 0;
    repeat (14) begin
      tick(1, 1, 0);
      if (pc == 8'd1) c_a++;
    end
    check_eq("dec_loop_count", c_a, 3);
    check_eq("dec_loop_end", {24'd0, pc, 5'd0, busy, halted, err}, {24'd5, 8'b0000_0010});
    $display("scenario dec_loop done");

    // WAITIN: sensor after 4 cycles, timeout, sensor already high
    for (int v = 0; v < 3; v++) begin
      clear_prog();
      prog[0] = mk(T_WAITIN, 2, 10); prog[1] = mk(T_JTO, 0, 5); prog[2] = mk(T_ON, 0, 0);
      prog[5] = mk(T_ON, 3, 0);
      tick(0, 1, 0);
      c_a = 0;
      for (int i = 0; i < 16; i++) begin
        s = (v == 2 || (v == 0 && i >= 4)) ? 4'b0100 : 4'b0000;
        tick(1, 1, s);
        if (busy) c_a++;
      end
      check_eq("waitin_busy_cycles", c_a, (v == 0) ? 4 : (v == 1) ? 9 : 0);
      check_eq("waitin_jto_act", {28'd0, act}, (v == 1) ? 32'h8 : 32'h1);
      $display("scenario waitin variant %0d done", v);
    end

    // Five nested CALLs overflow a 4-deep stack
    clear_prog();
    for (int i = 0; i < 5; i++) prog[i] = mk(T_CALL, 0, 16'(i + 1));
    tick(0, 1, 0);
    repeat (8) tick(1, 1, 0);
    check_eq("call_overflow", {24'd0, pc, 5'd0, busy, halted, err}, {24'd4, 8'b0000_0011});
    $display("scenario call_overflow done");

    // CALL/RET round trip
    clear_prog();
    prog[0] = mk(T_CALL, 0, 4); prog[1] = mk(T_ON, 0, 0);
    prog[4] = mk(T_ON, 2, 0);   prog[5] = mk(T_RET, 0, 0);
    tick(0, 1, 0);
    repeat (8) tick(1, 1, 0);
    check_eq("call_ret", {20'd0, pc, act, busy, halted, err}, {20'd2, 4'b0101, 3'b010});
    $display("scenario call_ret done");

    // ena low mid-WAIT 8 freezes the remaining count
    clear_prog();
    prog[0] = mk(T_WAIT, 0, 8);
    tick(0, 1, 0);
    c_a = 0;
    repeat (3) begin tick(1, 1, 0); if (busy) c_a++; end
    repeat (20) tick(1, 0, 0);
    repeat (12) begin tick(1, 1, 0); if (busy) c_a++; end
    check_eq("wait8_enabled_busy", c_a, 8);
    check_eq("wait8_pc_end", {24'd0, pc}, 1);
    $display("scenario wait_ena_hold done");

    // Reset mid-WAIT, with ena low
    tick(0, 1, 0);
    repeat (3) tick(1, 1, 0);
    tick(0, 0, 0);
    check_eq("reset_mid_wait", {24'd0, pc, 6'd0, busy, halted}, 0);
    $display("scenario reset_mid_wait done");

    // Undefined opcode keeps act
    clear_prog();
    prog[0] = mk(T_ON, 3, 0); prog[1] = mk(8'h77, 0, 0);
    tick(0, 1, 0);
    repeat (5) tick(1, 1, 0);
    check_eq("bad_opcode", {20'd0, pc, act, busy, halted, err}, {20'd1, 4'b1000, 3'b011});
    $display("scenario bad_opcode done");

    // pc wrap 255 -> 0 and DEC wrap 0 -> FFFF
    clear_prog();
    prog[0] = mk(T_JZ, 0, 2); prog[1] = mk(T_HALT, 0, 0); prog[2] = mk(T_ON, 1, 0);
    prog[3] = mk(T_J, 0, 255); prog[255] = mk(T_DEC, 0, 0);
    tick(0, 1, 0);
    repeat (9) tick(1, 1, 0);
    check_eq("pc_wrap", {20'd0, pc, act, busy, halted, err}, {20'd1, 4'b0010, 3'b010});
    $display("scenario pc_wrap done");

    // Random programs, random ena/sens, occasional reset
    for (int p = 0; p < 40; p++) begin
      clear_prog();
      for (int a = 0; a < 32; a++) prog[a] = rand_instr();
      tick(0, 1, 0);
      for (int i = 0; i < 150; i++) begin
        s[0] = ($urandom_range(0, 4) == 0);
        s[1] = ($urandom_range(0, 4) == 0);
        s[2] = ($urandom_range(0, 4) == 0);
        s[3] = ($urandom_range(0, 4) == 0);
        tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 6) != 0), s);
      end
      $display("scenario random program %0d done", p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
